// File: rtl/biker_move.sv
// biker_move: per-frame biker position/pose controller (keys, collision, startOfFrame in; topLeftX/Y, turnLeft/Right, bouncing out)
module biker_move #(
  parameter int INITIAL_X     = 304,
  parameter int INITIAL_Y     = 400,
  parameter int X_SPEED       = 4,
  parameter int X_MIN         = 0,
  parameter int X_MAX         = 608,
  parameter int Y_MIN         = 0,
  parameter int Y_MAX         = 448,
  parameter int BOUNCE_PIXELS = 16,
  parameter int BOUNCE_FRAMES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        leftPressed,
  input  logic        rightPressed,
  input  logic        collision,
  input  logic [3:0]  HitEdgeCode,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        turnLeft,
  output logic        turnRight,
  output logic        bouncing
);
  typedef enum logic [1:0] {STRAIGHT, LEFT, RIGHT, BOUNCE} state_t;
  localparam logic signed [11:0] XS  = 12'(X_SPEED);
  localparam logic signed [11:0] BP  = 12'(BOUNCE_PIXELS);
  localparam logic signed [11:0] XLO = 12'(X_MIN);
  localparam logic signed [11:0] XHI = 12'(X_MAX);
  localparam logic signed [11:0] YLO = 12'(Y_MIN);
  localparam logic signed [11:0] YHI = 12'(Y_MAX);
  state_t state_q, state_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic [3:0] hit_q, hit_d;
  logic [7:0] cnt_q, cnt_d;
  logic key_l, key_r, in_bounce, bounce_now;
  logic signed [11:0] dx, dy, xs, ys, xcl, ycl;
  always_comb begin
    key_l      = leftPressed & ~rightPressed;
    key_r      = rightPressed & ~leftPressed;
    in_bounce  = state_q == BOUNCE;
    bounce_now = !in_bounce && hit_q != 4'b0;
    dx  = in_bounce ? 12'sd0 : bounce_now ? (hit_q[3] ? BP : 12'sd0) - (hit_q[1] ? BP : 12'sd0) :
          key_l ? -XS : key_r ? XS : 12'sd0;
    dy  = bounce_now ? (hit_q[2] ? BP : 12'sd0) - (hit_q[0] ? BP : 12'sd0) : 12'sd0;
    xs  = $signed({1'b0, x_q}) + dx;
    ys  = $signed({1'b0, y_q}) + dy;
    xcl = xs < XLO ? XLO : xs > XHI ? XHI : xs;
    ycl = ys < YLO ? YLO : ys > YHI ? YHI : ys;
  end
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q | ((collision && !in_bounce) ? HitEdgeCode : 4'b0);
    if (startOfFrame) begin
      hit_d = (collision && !in_bounce) ? HitEdgeCode : 4'b0;
      x_d   = xcl[10:0];
      y_d   = ycl[10:0];
      if (in_bounce) begin
        state_d = cnt_q == 8'd0 ? STRAIGHT : BOUNCE;
        cnt_d   = cnt_q == 8'd0 ? cnt_q : cnt_q - 8'd1;
      end else if (bounce_now) begin
        state_d = BOUNCE;
        cnt_d   = 8'(BOUNCE_FRAMES - 1);
      end else begin
        state_d = key_l ? LEFT : key_r ? RIGHT : STRAIGHT;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STRAIGHT;
      x_q     <= 11'(INITIAL_X);
      y_q     <= 11'(INITIAL_Y);
      hit_q   <= 4'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hit_q   <= hit_d;
      cnt_q   <= cnt_d;
    end
  end
  assign topLeftX  = x_q;
  assign topLeftY  = y_q;
  assign turnLeft  = state_q == LEFT;
  assign turnRight = state_q == RIGHT;
  assign bouncing  = state_q == BOUNCE;
endmodule

// File: tb/tb_biker_move.sv
// tb_biker_move: scoreboard bench for biker_move driven by directed frames
module tb_biker_move;
  logic clk = 0;
  logic reset = 0, startOfFrame = 0, leftPressed = 0, rightPressed = 0, collision = 0;
  logic [3:0] HitEdgeCode = 0;
  logic [10:0] topLeftX, topLeftY;
  logic turnLeft, turnRight, bouncing;
  int checks = 0, errors = 0;
  logic [24:0] exp_q[$];
  string name_q[$];
  biker_move dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .leftPressed(leftPressed), .rightPressed(rightPressed),
    .collision(collision), .HitEdgeCode(HitEdgeCode),
    .topLeftX(topLeftX), .topLeftY(topLeftY),
    .turnLeft(turnLeft), .turnRight(turnRight), .bouncing(bouncing)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (reset || startOfFrame) begin
      #1;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got x=%0d y=%0d l=%0b r=%0b b=%0b want nothing", topLeftX, topLeftY, turnLeft, turnRight, bouncing);
      end else begin
        logic [24:0] e, a;
        string nm;
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        a = {topLeftX, topLeftY, turnLeft, turnRight, bouncing};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s got x=%0d y=%0d l=%0b r=%0b b=%0b want x=%0d y=%0d l=%0b r=%0b b=%0b",
                   nm, a[24:14], a[13:3], a[2], a[1], a[0], e[24:14], e[13:3], e[2], e[1], e[0]);
        end
      end
    end
  end
  task automatic expect_out(input int x, input int y, input logic tl, tr, b, input string nm);
    exp_q.push_back({11'(x), 11'(y), tl, tr, b});
    name_q.push_back(nm);
  endtask
  task automatic do_reset(input string nm);
    @(negedge clk);
    reset = 1;
    expect_out(304, 400, 0, 0, 0, nm);
    @(negedge clk);
    reset = 0;
  endtask
  task automatic frame(input logic l, r, c, input logic [3:0] code,
                       input int x, y, input logic tl, tr, b, input string nm);
    @(negedge clk);
    leftPressed = l; rightPressed = r; collision = c; HitEdgeCode = code; startOfFrame = 1;
    expect_out(x, y, tl, tr, b, nm);
    @(negedge clk);
    startOfFrame = 0; collision = 0; HitEdgeCode = 0;
    repeat (3) @(negedge clk);
  endtask
  task automatic hit(input logic [3:0] code);
    @(negedge clk);
    collision = 1; HitEdgeCode = code;
    @(negedge clk);
    collision = 0; HitEdgeCode = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    do_reset("reset");
    frame(1, 0, 0, 0, 300, 400, 1, 0, 0, "left1");
    frame(1, 0, 0, 0, 296, 400, 1, 0, 0, "left2");
    frame(1, 0, 0, 0, 292, 400, 1, 0, 0, "left3");
    for (int x = 288; x >= 8; x -= 4) frame(1, 0, 0, 0, x, 400, 1, 0, 0, "left_run");
    frame(1, 0, 0, 0, 4, 400, 1, 0, 0, "left_to4");
    frame(1, 0, 0, 0, 0, 400, 1, 0, 0, "left_to0");
    frame(1, 0, 0, 0, 0, 400, 1, 0, 0, "left_clamp");
    for (int x = 4; x <= 304; x += 4) frame(0, 1, 0, 0, x, 400, 0, 1, 0, "right_run");
    frame(1, 1, 0, 0, 304, 400, 0, 0, 0, "both_keys");
    frame(0, 0, 0, 0, 304, 400, 0, 0, 0, "no_keys");
    hit(4'b1000);
    frame(0, 0, 0, 0, 320, 400, 0, 0, 1, "bounce_left_edge");
    for (int i = 1; i <= 8; i++) frame(0, 1, 0, 0, 320, 400, 0, 0, i < 8, "bounce_hold");
    frame(0, 1, 0, 0, 324, 400, 0, 1, 0, "after_bounce_right");
    frame(0, 0, 1, 4'b0101, 324, 400, 0, 0, 0, "hit_on_sof_deferred");
    frame(0, 0, 0, 0, 324, 400, 0, 0, 1, "top_bottom_cancel");
    do_reset("reset_mid_bounce");
    frame(0, 0, 0, 0, 304, 400, 0, 0, 0, "post_reset_idle");
    hit(4'b0010);
    frame(0, 0, 0, 0, 288, 400, 0, 0, 1, "bounce_right_edge");
    hit(4'b1000);
    for (int i = 1; i <= 8; i++) frame(1, 0, 0, 0, 288, 400, 0, 0, i < 8, "bounce_ignores_hit");
    frame(0, 0, 0, 0, 288, 400, 0, 0, 0, "latch_clear_after_bounce");
    hit(4'b0100);
    frame(0, 0, 0, 0, 288, 416, 0, 0, 1, "bounce_top_edge");
    for (int i = 1; i <= 8; i++) frame(0, 0, 0, 0, 288, 416, 0, 0, i < 8, "bounce_y_hold");
    frame(1, 0, 0, 0, 284, 416, 1, 0, 0, "left_keeps_y");
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_outputs got %0d left want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
